// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the tribuf8 bus arbiter:
//                FSM state type, owner index width and parameter defaults.
//                Optional feature macro used by bus_arbiter: BUS_ARB_TIMEOUT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    // Owner index is always carried on 3 bits, enough for up to 8 requesters
    localparam int c_owner_w         = 3;

    // Parameter defaults for bus_arbiter
    localparam int c_def_nreq        = 4;
    localparam int c_def_turn_cycles = 1;
    localparam int c_def_max_hold    = 16;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches req starting at
//                last_owner+1 (wrapping at NREQ) and returns the first high
//                request index together with a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ = c_def_nreq
) (
    input  logic [NREQ-1:0]      req,
    input  logic [c_owner_w-1:0] last_owner,
    output logic                 valid,
    output logic [c_owner_w-1:0] index
);

    // One extra bit so last_owner + offset cannot overflow before the wrap
    localparam int c_pos_w = c_owner_w + 1;

    logic [c_pos_w-1:0] w_pos;

    // Walk offsets 1..NREQ from last_owner; the first high request wins
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_pos = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = {1'b0, last_owner} + c_pos_w'(k);
            if (w_pos >= c_pos_w'(NREQ)) begin
                w_pos = w_pos - c_pos_w'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (w_pos == c_pos_w'(j))) begin
                    valid = 1'b1;
                    index = c_owner_w'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter for NREQ requesters sharing one tribuf8
//                bus. Grants are registered one-hot; output enables mirror the
//                grant. A dead phase of TURN_CYCLES cycles separates owners.
//                Optional macro BUS_ARB_TIMEOUT_EN: revoke a grant held for
//                MAX_HOLD cycles when another requester is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ        = c_def_nreq,
    parameter int TURN_CYCLES = c_def_turn_cycles,
    parameter int MAX_HOLD    = c_def_max_hold
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      oe,
    output logic [c_owner_w-1:0] owner,
    output logic                 busy
);

    // After reset the search starts at NREQ-1+1 = 0, giving requester 0 priority
    localparam logic [c_owner_w-1:0] c_last_init = c_owner_w'(NREQ - 1);
    localparam logic [1:0]           c_turn_last = 2'(TURN_CYCLES - 1);

    arb_state_t             r_state;
    logic [NREQ-1:0]        r_gnt;
    logic [NREQ-1:0]        r_oe;
    logic [c_owner_w-1:0]   r_owner;
    logic [c_owner_w-1:0]   r_last_owner;
    logic                   r_busy;
    logic [1:0]             r_turn_cnt;

    logic                   w_valid;
    logic [c_owner_w-1:0]   w_index;
    logic [NREQ-1:0]        w_onehot;
    logic                   w_owner_req;
    logic                   w_timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int                  c_hold_w   = $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);

    logic [c_hold_w-1:0]    r_hold_cnt;
    logic                   w_other_req;

    // Another requester is waiting while the current owner sits at the limit
    assign w_other_req = |(req & ~r_gnt);
    assign w_timeout   = w_other_req && (r_hold_cnt == c_hold_max);
`else
    logic                   w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (MAX_HOLD != 0);
`endif

    rr_pick #(
        .NREQ       (NREQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .valid      (w_valid),
        .index      (w_index)
    );

    // Decode the picked index to one-hot and fetch the current owner's request
    always_comb begin
        w_onehot    = '0;
        w_owner_req = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_index == c_owner_w'(j)) begin
                w_onehot[j] = 1'b1;
            end
            if (r_owner == c_owner_w'(j)) begin
                w_owner_req = req[j];
            end
        end
    end

    // Arbiter FSM with registered grant, enable, owner and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_oe         <= '0;
            r_owner      <= '0;
            r_last_owner <= c_last_init;
            r_busy       <= 1'b0;
            r_turn_cnt   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state      <= GRANT;
                        r_gnt        <= w_onehot;
                        r_oe         <= w_onehot;
                        r_owner      <= w_index;
                        r_last_owner <= w_index;
                        r_busy       <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                        r_hold_cnt   <= c_hold_w'(1);
`endif
                    end
                end
                GRANT: begin
                    if (!w_owner_req || w_timeout) begin
                        r_state    <= TURN;
                        r_gnt      <= '0;
                        r_oe       <= '0;
                        r_owner    <= '0;
                        r_turn_cnt <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
`endif
                    end
                end
                TURN: begin
                    // Requests are ignored here; the next pick happens in IDLE
                    if (r_turn_cnt == c_turn_last) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_turn_cnt <= '0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_oe    <= '0;
                    r_owner <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign oe    = r_oe;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Directed scenarios plus
//                randomized request traffic, compared every cycle against a
//                behavioural model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int NREQ        = 4;
    localparam int TURN_CYCLES = 1;
    localparam int MAX_HOLD    = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] oe;
    logic [2:0]      owner;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner index (-1 = none), dead cycles left, hold length
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_turn  = 0;
    int m_hold  = 0;

    // Bookkeeping for the grant-separation property
    logic [NREQ-1:0] prev_gnt   = '0;
    int              zero_run   = 0;
    bit              seen_grant = 1'b0;

    bus_arbiter #(
        .NREQ        (NREQ),
        .TURN_CYCLES (TURN_CYCLES),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .oe    (oe),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First high request after position last, wrapping modulo NREQ
    function automatic int rr_next(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_step();
        int  p;
        bit  others;
        if (rst) begin
            m_owner    = -1;
            m_last     = NREQ - 1;
            m_turn     = 0;
            m_hold     = 0;
            seen_grant = 1'b0;
        end else if (m_owner >= 0) begin
            others = 1'b0;
            for (int i = 0; i < NREQ; i++) if (i != m_owner && req[i]) others = 1'b1;
            if (!req[m_owner]) begin
                m_owner = -1;
                m_turn  = TURN_CYCLES;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (m_hold >= MAX_HOLD && others) begin
                m_owner = -1;
                m_turn  = TURN_CYCLES;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
`endif
        end else if (m_turn > 0) begin
            m_turn--;
        end else begin
            p = rr_next(m_last, req);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_hold  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        int unsigned     exp_gnt;
        logic [NREQ-1:0] g_minus;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check_value("gnt", gnt, exp_gnt);
        check_value("oe", oe, exp_gnt);
        check_value("owner", owner, (m_owner >= 0) ? m_owner : 0);
        check_value("busy", busy, (m_owner >= 0 || m_turn > 0) ? 1 : 0);
        g_minus = gnt - 1'b1;
        check_value("onehot", ((gnt & g_minus) == '0) ? 1 : 0, 1);
        if (gnt != '0) begin
            if (prev_gnt != '0) check_value("owner_change_without_gap", gnt, prev_gnt);
            else if (seen_grant) check_value("dead_gap_ok", (zero_run >= TURN_CYCLES + 1) ? 1 : 0, 1);
            seen_grant = 1'b1;
            zero_run   = 0;
        end else begin
            zero_run++;
        end
        prev_gnt = gnt;
    endtask

    // One clock: drive inputs at the falling edge, step model, check next fall
    task automatic run_cycle(input logic r, input logic [NREQ-1:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int              age;
        logic [NREQ-1:0] q;
        logic [NREQ-1:0] want;
        logic [NREQ-1:0] last_obs;
        int              order[$];

        @(negedge clk);

        // Reset state
        repeat (3) run_cycle(1'b1, '0);
        check_value("rst_gnt", gnt, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_owner", owner, 0);

        // Single request: grant after one cycle, release with one TURN cycle
        run_cycle(1'b0, 4'b0001);
        check_value("single_gnt", gnt, 4'b0001);
        check_value("single_busy", busy, 1);
        repeat (4) run_cycle(1'b0, 4'b0001);
        run_cycle(1'b0, 4'b0000);
        check_value("single_release_gnt", gnt, 0);
        check_value("single_turn_busy", busy, 1);
        run_cycle(1'b0, 4'b0000);
        check_value("single_idle_busy", busy, 0);

        // Round robin with all requesting; each owner lets go after 3 cycles
        run_cycle(1'b1, '0);
        age      = 0;
        last_obs = '0;
        for (int c = 0; c < 40; c++) begin
            q = 4'b1111;
            if (gnt != '0 && age >= 3) q = ~gnt;
            run_cycle(1'b0, q);
            if (gnt != '0) begin
                if (last_obs == '0) order.push_back(int'(owner));
                age++;
            end else begin
                age = 0;
            end
            last_obs = gnt;
        end
        check_value("rr_count", (order.size() >= 5) ? 1 : 0, 1);
        if (order.size() >= 5) begin
            check_value("rr_0", order[0], 0);
            check_value("rr_1", order[1], 1);
            check_value("rr_2", order[2], 2);
            check_value("rr_3", order[3], 3);
            check_value("rr_4", order[4], 0);
        end

        // Reset mid-grant: owner 2 loses the bus, then wins again from reset priority
        run_cycle(1'b1, '0);
        repeat (3) run_cycle(1'b0, 4'b0100);
        check_value("pre_rst_gnt", gnt, 4'b0100);
        run_cycle(1'b1, 4'b0100);
        check_value("mid_rst_gnt", gnt, 0);
        run_cycle(1'b0, 4'b0100);
        check_value("post_rst_gnt", gnt, 4'b0100);

        // Lone requester keeps the bus well past MAX_HOLD
        run_cycle(1'b1, '0);
        repeat (45) run_cycle(1'b0, 4'b0001);
        check_value("long_hold_gnt", gnt, 4'b0001);

        // Handover between two requesters, then randomized traffic
        run_cycle(1'b0, 4'b0011);
        run_cycle(1'b0, 4'b0010);
        repeat (6) run_cycle(1'b0, 4'b0010);
        check_value("handover_gnt", gnt, 4'b0010);

        want = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (want[i]) begin
                    if ($urandom_range(0, 5) == 0) want[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                end
            end
            run_cycle(($urandom_range(0, 199) == 0), want);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one tribuf8 bus (2..8).
REQ-002 Parameter TURN_CYCLES, default 1, dead cycles with all enables low between owners (1..4).
REQ-003 Parameter MAX_HOLD, default 16, grant-length limit in cycles, used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  NREQ  level request per requester; held high for as long as the bus is wanted.
REQ-007 gnt  output  NREQ  registered one-hot grant, or all-zero.
REQ-008 oe  output  NREQ  registered output_en per requester's tribuf8; identical to gnt every cycle.
REQ-009 owner  output  3  index of the granted requester; 0 when none is granted.
REQ-010 busy  output  1  high in GRANT and TURN states.

Function
REQ-011 FSM states: IDLE, GRANT, TURN.
REQ-012 IDLE: if any req is high, the picked requester is granted at the next edge and the FSM goes to GRANT; otherwise it stays in IDLE.
REQ-013 Request-to-grant latency from IDLE is exactly 1 cycle.
REQ-014 Arbitration is round-robin: search starts at last_owner+1 modulo NREQ and picks the first high req.
REQ-015 last_owner updates only when a grant is issued.
REQ-016 GRANT: gnt and oe stay constant while req[owner] stays high.
REQ-017 In GRANT, when req[owner] is sampled low, gnt and oe go all-zero at the next edge and the FSM enters TURN.
REQ-018 TURN lasts exactly TURN_CYCLES cycles with gnt and oe all-zero, then goes to IDLE; requests are ignored during TURN.
REQ-019 gnt and oe are never non-zero in two consecutive cycles for different owners; at least TURN_CYCLES+1 zero cycles separate any two grants, counting TURN and IDLE.
REQ-020 A requester re-asserting req during its own TURN gets no priority; it waits for the next IDLE round-robin pick.
REQ-021 Simultaneous requests in IDLE are resolved by REQ-014 alone; ties cannot occur.
REQ-022 Requests from indices >= NREQ do not exist; the owner width is fixed at 3 bits and unused upper values are never driven.

Reset
REQ-023 On rst: FSM goes to IDLE; gnt, oe, owner and busy are 0; last_owner is NREQ-1, so requester 0 has top priority first; the TURN and hold counters are 0.
REQ-024 rst asserted during GRANT drops gnt and oe at that same edge, with no TURN phase.
REQ-025 The first grant is possible at the edge after the first cycle in which rst is low.

Configuration
REQ-026 When the macro BUS_ARB_TIMEOUT_EN is defined:
- a hold counter counts GRANT cycles;
- when it reaches MAX_HOLD and any other req is high, the grant is revoked at the next edge and the FSM goes to TURN;
- the revoked requester is then lowest priority.
REQ-027 Timeout with no other request pending: the grant continues and the counter saturates.
REQ-028 When BUS_ARB_TIMEOUT_EN is undefined: no hold counter exists, and the grant lasts until req[owner] falls.

Structure
REQ-029 Shared package bus_arb_pkg holds:
- the state enum type (IDLE/GRANT/TURN);
- the owner width constant (3);
- default constants for NREQ, TURN_CYCLES and MAX_HOLD.
REQ-030 One sub-module, rr_pick, is purely combinational: inputs req and last_owner; outputs valid and index.
REQ-031 bus_arbiter instantiates one rr_pick; gnt and oe are driven from flops only.

Verification
REQ-032 Single request, NREQ=4: after reset, req=0001 at cycle 0 -> gnt=oe=0001, owner=0 and busy=1 at cycle 1; req low at cycle 5 -> gnt=0000 at cycle 6 and busy=0 at cycle 7.
REQ-033 Round-robin: req=1111 held, each owner drops req after 3 cycles of grant and re-raises it -> grant order 0,1,2,3,0 with 2 zero cycles between grants (TURN_CYCLES=1).
REQ-034 Handover: req=0011, owner 0 releases -> gnt=0000 during TURN and IDLE, then gnt=0010; assert gnt&(gnt-1)==0 and no owner change without an intervening zero cycle, every cycle.
REQ-035 Reset mid-grant: owner 2 granted, rst pulsed 1 cycle -> gnt=0000 at the next edge; with req=0100 still high, gnt=0100 again one cycle after rst falls, since last_owner reset to 3.
REQ-036 Timeout (BUS_ARB_TIMEOUT_EN, MAX_HOLD=16): req=0011 held -> owner 0 revoked after 16 GRANT cycles, then owner 1 granted; with req=0001 only, owner 0 is held for 40 or more cycles.
